// File: rtl/alu_op_sequencer.sv
// Sequential front-end for the 6-bit mini ALU: loads fxn/A/B words, waits one
// settle cycle, captures the ALU result and offers it to a consumer.
module alu_op_sequencer #(
  parameter int WIDTH = 6,
  parameter int FXN_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic [FXN_W-1:0] alu_fxn,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_oflow,
  input  logic             alu_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_oflow,
  output logic             res_cout,
  output logic [CNT_W-1:0] op_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    LOAD_FXN = 3'd0,
    LOAD_A   = 3'd1,
    LOAD_B   = 3'd2,
    EXEC     = 3'd3,
    HOLD     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [FXN_W-1:0] fxn_q, fxn_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_oflow_q, res_oflow_d;
  logic             res_cout_q, res_cout_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  // Handshakes: a transfer happens only on an edge where valid && ready are
  // both high; ready is decoded from state alone and never looks at valid.
  always_comb begin
    state_d     = state_q;
    fxn_d       = fxn_q;
    a_d         = a_q;
    b_d         = b_q;
    res_data_d  = res_data_q;
    res_oflow_d = res_oflow_q;
    res_cout_d  = res_cout_q;
    op_count_d  = op_count_q;
    in_ready    = 1'b0;
    res_valid   = 1'b0;

    case (state_q)
      LOAD_FXN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fxn_d   = in_data[FXN_W-1:0];
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_data;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          b_d     = in_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Operands have been stable for a full cycle; the ALU has settled.
        res_data_d  = alu_out;
        res_oflow_d = alu_oflow;
        res_cout_d  = alu_cout;
        state_d     = HOLD;
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (op_count_q != {CNT_W{1'b1}}) op_count_d = op_count_q + CNT_W'(1);
          state_d = LOAD_FXN;
        end
      end
      default: state_d = LOAD_FXN;
    endcase

    // Abort wins over everything and leaves all datapath registers untouched.
    if (flush) begin
      state_d     = LOAD_FXN;
      fxn_d       = fxn_q;
      a_d         = a_q;
      b_d         = b_q;
      res_data_d  = res_data_q;
      res_oflow_d = res_oflow_q;
      res_cout_d  = res_cout_q;
      op_count_d  = op_count_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= LOAD_FXN;
      fxn_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_data_q  <= '0;
      res_oflow_q <= 1'b0;
      res_cout_q  <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      fxn_q       <= fxn_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_data_q  <= res_data_d;
      res_oflow_q <= res_oflow_d;
      res_cout_q  <= res_cout_d;
      op_count_q  <= op_count_d;
    end
  end

  assign alu_fxn   = fxn_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign res_data  = res_data_q;
  assign res_oflow = res_oflow_q;
  assign res_cout  = res_cout_q;
  assign op_count  = op_count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; a second instance with a 2-bit counter
// shares all inputs and is used for the saturation scenario.
module tb_alu_op_sequencer;

  localparam logic [2:0] S_LOAD_FXN = 3'd0;
  localparam logic [2:0] S_LOAD_A   = 3'd1;
  localparam logic [2:0] S_LOAD_B   = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       flush;
  logic [2:0] alu_fxn;
  logic [5:0] alu_a, alu_b;
  logic [5:0] alu_out;
  logic       alu_oflow, alu_cout;
  logic       res_valid;
  logic       res_ready;
  logic [5:0] res_data;
  logic       res_oflow, res_cout;
  logic [7:0] op_count;
  logic [2:0] state_dbg;

  logic       s_in_ready, s_res_valid, s_res_oflow, s_res_cout;
  logic [2:0] s_alu_fxn, s_state_dbg;
  logic [5:0] s_alu_a, s_alu_b, s_res_data;
  logic [1:0] s_op_count;

  int n_vec = 0;
  int n_err = 0;

  alu_op_sequencer #(.WIDTH(6), .FXN_W(3), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .alu_fxn(alu_fxn), .alu_a(alu_a),
    .alu_b(alu_b), .alu_out(alu_out), .alu_oflow(alu_oflow), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_oflow(res_oflow), .res_cout(res_cout), .op_count(op_count),
    .state_dbg(state_dbg)
  );

  alu_op_sequencer #(.WIDTH(6), .FXN_W(3), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .flush(flush), .alu_fxn(s_alu_fxn), .alu_a(s_alu_a),
    .alu_b(s_alu_b), .alu_out(alu_out), .alu_oflow(alu_oflow), .alu_cout(alu_cout),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_data(s_res_data),
    .res_oflow(s_res_oflow), .res_cout(s_res_cout), .op_count(s_op_count),
    .state_dbg(s_state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // driver tasks: inputs change at negedge, outputs sampled at negedge
  task automatic send_word(input logic [5:0] w);
    int t;
    in_valid = 1'b1;
    in_data  = w;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin $display("FAIL send_wait: in_ready got %b want 1", in_ready); n_err++; end
    n_vec++;
    @(negedge clk);
  endtask

  // Leaves the DUT in HOLD, sampled at a negedge.
  task automatic run_frame(input logic [5:0] f, input logic [5:0] a, input logic [5:0] b);
    send_word(f);
    send_word(a);
    send_word(b);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    if ({alu_fxn, alu_a, alu_b} !== 15'd0) begin $display("FAIL reset_alu: got %h want 0", {alu_fxn, alu_a, alu_b}); n_err++; end
    n_vec++;
    if ({res_data, res_oflow, res_cout, res_valid} !== 9'd0) begin $display("FAIL reset_res: got %h want 0", {res_data, res_oflow, res_cout, res_valid}); n_err++; end
    n_vec++;
    if (op_count !== 8'd0) begin $display("FAIL reset_cnt: got %0d want 0", op_count); n_err++; end
    n_vec++;
    if (in_ready !== 1'b1) begin $display("FAIL reset_rdy: got %b want 1", in_ready); n_err++; end
    n_vec++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({in_ready, res_valid} !== 2'b10) begin $display("FAIL idle_%0d: rdy/vld got %b want 10", i, {in_ready, res_valid}); n_err++; end
      n_vec++;
    end
  endtask

  task automatic test_single;
    alu_out = 6'h2A; alu_oflow = 1'b1; alu_cout = 1'b0;
    res_ready = 1'b1;
    in_valid = 1'b1; in_data = 6'h3D;
    @(negedge clk);
    if (alu_fxn !== 3'b101) begin $display("FAIL single_fxn: got %b want 101", alu_fxn); n_err++; end
    n_vec++;
    in_data = 6'h05;
    @(negedge clk);
    in_data = 6'h03;
    @(negedge clk);
    in_valid = 1'b0;
    if ({state_dbg, in_ready, res_valid} !== {S_EXEC, 2'b00}) begin $display("FAIL single_exec: st/rdy/vld got %b want %b", {state_dbg, in_ready, res_valid}, {S_EXEC, 2'b00}); n_err++; end
    n_vec++;
    if ({alu_a, alu_b} !== {6'd5, 6'd3}) begin $display("FAIL single_ab: got %h want %h", {alu_a, alu_b}, {6'd5, 6'd3}); n_err++; end
    n_vec++;
    @(negedge clk);
    if ({res_valid, res_data, res_oflow, res_cout} !== {1'b1, 6'h2A, 1'b1, 1'b0}) begin $display("FAIL single_res: got %h want %h", {res_valid, res_data, res_oflow, res_cout}, {1'b1, 6'h2A, 1'b1, 1'b0}); n_err++; end
    n_vec++;
    @(negedge clk);
    if ({res_valid, in_ready} !== 2'b01) begin $display("FAIL single_done: vld/rdy got %b want 01", {res_valid, in_ready}); n_err++; end
    n_vec++;
    if (op_count !== 8'd1) begin $display("FAIL single_cnt: got %0d want 1", op_count); n_err++; end
    n_vec++;
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    alu_out = 6'h11; alu_oflow = 1'b0; alu_cout = 1'b1;
    res_ready = 1'b0;
    run_frame(6'h02, 6'h07, 6'h09);
    in_valid = 1'b1; in_data = 6'h24;
    for (int i = 0; i < 7; i++) begin
      if ({res_valid, in_ready, res_data, res_oflow, res_cout} !== {1'b1, 1'b0, 6'h11, 1'b0, 1'b1}) begin $display("FAIL bp_hold_%0d: got %h want %h", i, {res_valid, in_ready, res_data, res_oflow, res_cout}, {1'b1, 1'b0, 6'h11, 1'b0, 1'b1}); n_err++; end
      n_vec++;
      if (alu_fxn !== 3'b010) begin $display("FAIL bp_fxn_%0d: got %b want 010", i, alu_fxn); n_err++; end
      n_vec++;
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    if ({state_dbg, alu_fxn, op_count} !== {S_LOAD_FXN, 3'b010, 8'd2}) begin $display("FAIL bp_release: got %h want %h", {state_dbg, alu_fxn, op_count}, {S_LOAD_FXN, 3'b010, 8'd2}); n_err++; end
    n_vec++;
    @(negedge clk);
    in_valid = 1'b0;
    if ({state_dbg, alu_fxn} !== {S_LOAD_A, 3'b100}) begin $display("FAIL bp_take: got %h want %h", {state_dbg, alu_fxn}, {S_LOAD_A, 3'b100}); n_err++; end
    n_vec++;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    if ({state_dbg, alu_fxn} !== {S_LOAD_FXN, 3'b100}) begin $display("FAIL bp_flush: got %h want %h", {state_dbg, alu_fxn}, {S_LOAD_FXN, 3'b100}); n_err++; end
    n_vec++;
  endtask

  task automatic test_gaps;
    alu_out = 6'h3F; alu_oflow = 1'b1; alu_cout = 1'b1;
    send_word(6'h07);
    send_word(6'h15);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ({state_dbg, alu_a} !== {S_LOAD_B, 6'h15}) begin $display("FAIL gap_%0d: st/a got %h want %h", i, {state_dbg, alu_a}, {S_LOAD_B, 6'h15}); n_err++; end
      n_vec++;
      @(negedge clk);
    end
    send_word(6'h2B);
    in_valid = 1'b0;
    @(negedge clk);
    if ({res_valid, res_data, res_oflow, res_cout, alu_fxn, alu_b} !== {1'b1, 6'h3F, 2'b11, 3'b111, 6'h2B}) begin $display("FAIL gap_res: got %h want %h", {res_valid, res_data, res_oflow, res_cout, alu_fxn, alu_b}, {1'b1, 6'h3F, 2'b11, 3'b111, 6'h2B}); n_err++; end
    n_vec++;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    if (op_count !== 8'd3) begin $display("FAIL gap_cnt: got %0d want 3", op_count); n_err++; end
    n_vec++;
  endtask

  task automatic test_flush;
    send_word(6'h01);
    send_word(6'h0A);
    in_valid = 1'b1; in_data = 6'h33; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    if ({state_dbg, alu_a, alu_b} !== {S_LOAD_FXN, 6'h0A, 6'h2B}) begin $display("FAIL flush_ldb: got %h want %h", {state_dbg, alu_a, alu_b}, {S_LOAD_FXN, 6'h0A, 6'h2B}); n_err++; end
    n_vec++;

    alu_out = 6'h05; alu_oflow = 1'b0; alu_cout = 1'b0;
    run_frame(6'h03, 6'h01, 6'h02);
    if ({res_valid, res_data} !== {1'b1, 6'h05}) begin $display("FAIL flush_pre: got %h want %h", {res_valid, res_data}, {1'b1, 6'h05}); n_err++; end
    n_vec++;
    flush = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; res_ready = 1'b0;
    if ({res_valid, state_dbg, res_data, op_count} !== {1'b0, S_LOAD_FXN, 6'h05, 8'd3}) begin $display("FAIL flush_hold: got %h want %h", {res_valid, state_dbg, res_data, op_count}, {1'b0, S_LOAD_FXN, 6'h05, 8'd3}); n_err++; end
    n_vec++;

    alu_out = 6'h3A; alu_oflow = 1'b1; alu_cout = 1'b1;
    run_frame(6'h06, 6'h3C, 6'h3E);
    if ({res_valid, res_data} !== {1'b1, 6'h3A}) begin $display("FAIL rst_pre: got %h want %h", {res_valid, res_data}, {1'b1, 6'h3A}); n_err++; end
    n_vec++;
    #2 reset_n = 1'b0;
    #1;
    if ({res_valid, res_data, res_oflow, res_cout, alu_fxn, alu_a, alu_b, op_count} !== 32'd0) begin $display("FAIL rst_hold: got %h want 0", {res_valid, res_data, res_oflow, res_cout, alu_fxn, alu_a, alu_b, op_count}); n_err++; end
    n_vec++;
    if ({in_ready, state_dbg} !== {1'b1, S_LOAD_FXN}) begin $display("FAIL rst_state: got %h want %h", {in_ready, state_dbg}, {1'b1, S_LOAD_FXN}); n_err++; end
    n_vec++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_saturation;
    logic [1:0] exp_sat [5];
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3; exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
    alu_out = 6'h01; alu_oflow = 1'b0; alu_cout = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_frame(6'h00, 6'(i), 6'h01);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      if (s_op_count !== exp_sat[i]) begin $display("FAIL sat_%0d: got %0d want %0d", i, s_op_count, exp_sat[i]); n_err++; end
      n_vec++;
      if (op_count !== 8'(i + 1)) begin $display("FAIL cnt_%0d: got %0d want %0d", i, op_count, i + 1); n_err++; end
      n_vec++;
    end
  endtask

  initial begin
    reset_n = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
    alu_out = '0; alu_oflow = 1'b0; alu_cout = 1'b0; res_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_gaps();
    test_flush();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
